mem_boot_loader: RTL and testbench
==================================

Name: mem_boot_loader

Overview:
- Streams program and data images into instruction memory and data memory before the single-cycle MIPS core runs.
- Replaces the wide flattened parallel preload buses with a word-serial valid/ready input.
- Sits upstream of InstMem/DataMem write ports and of the core's reset input.
- Holds the core in reset until a frame marked final has loaded cleanly.

Parameters:
- IM_WORDS, 16, instruction memory depth in 32-bit words.
- DM_WORDS, 512, data memory depth in 32-bit words.
- IDX_W, 9, width of header base/count fields; must satisfy 2**IDX_W >= max(IM_WORDS, DM_WORDS).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  loader accepts a word; a transfer occurs when in_valid && in_ready.
- in_data  in  32  header or payload word.
- in_last  in  1  marks the final word of a frame.
- wr_en  out  1  one-cycle memory write strobe.
- wr_sel  out  1  target memory: 0 = InstMem, 1 = DataMem.
- wr_addr  out  32  byte address, word aligned: (base+offset)<<2.
- wr_data  out  32  word to write.
- cpu_rst  out  1  reset to the MIPS core, active high.
- busy  out  1  a frame is in progress (state DATA).
- done  out  1  final frame loaded; core released.
- err  out  1  sticky protocol error.
- words_loaded  out  IDX_W+1  total payload words written since reset.

Behaviour:
- Reset (synchronous, active-high):
  - state=HDR, in_ready=1, wr_en=0, wr_sel=0, wr_addr=0, wr_data=0.
  - cpu_rst=1, busy=0, done=0, err=0, words_loaded=0.
  - Reset asserted mid-frame aborts the frame. Writes already issued stand; no further wr_en.
- Header word format:
  - bit31 target (0 IM, 1 DM).
  - bit30 final flag.
  - bits[16+IDX_W-1:16] = count-1.
  - bits[IDX_W-1:0] = base word index.
  - All other bits ignored.
- State HDR (in_ready=1). On a transfer:
  - Error when either is true: base+count > depth(target), using IDX_W+1-bit arithmetic with no wrap; or in_last=1 on the header. Either error -> ERR.
  - Otherwise latch target, final, base, and remaining=count-1, set offset=0, then -> DATA.
- State DATA (in_ready=1, busy=1). On each transfer:
  - Next cycle: wr_en=1, wr_sel=target, wr_addr=(base+offset)<<2, wr_data=in_data. Latency is exactly 1 cycle.
  - offset increments and words_loaded increments.
  - If remaining==0 and in_last=1: -> DONE if final, else -> HDR.
  - If remaining==0 and in_last=0, or remaining!=0 and in_last=1: -> ERR. No write is issued for that word.
  - Otherwise remaining decrements.
- No back-pressure in HDR/DATA: the loader accepts one word per cycle indefinitely.
- in_valid=0 cycles insert bubbles and do not change state.
- State DONE:
  - in_ready=0, done=1.
  - cpu_rst falls to 0 on the clock edge that enters DONE, and stays 0.
  - Further input is ignored.
  - Leaves DONE only on rst.
- State ERR:
  - in_ready=0, err=1, cpu_rst=1.
  - Sticky until rst.
  - A write scheduled by the previous valid word still completes.
- wr_en is never high for two consecutive cycles unless two consecutive transfers occurred.
- wr_en is never high in the cycle after entering HDR from reset.
- words_loaded saturates at its maximum value rather than wrapping.

Decomposition:
- Package mem_boot_pkg:
  - state enum {HDR, DATA, DONE, ERR}.
  - Header field bit positions: TGT_BIT=31, FINAL_BIT=30, CNT_LSB=16.
  - Target encodings TGT_IM=0, TGT_DM=1.
- Optional sub-module mem_boot_hdr_check: purely combinational decode and bound check, producing target, final, base, count and hdr_bad.
- The main module holds the FSM, the counters and the registered write port.

Test Plan:
- IM load: header 32'h4003_0000 (IM, final, count 4, base 0), then 4 words with in_last on the 4th -> wr_en on 4 cycles at wr_addr 0,4,8,12, wr_sel=0; cpu_rst 1->0 entering DONE; done=1; words_loaded=4.
- Two frames: DM header 32'h8013_00FA (count 20, base 250) with 20 words, then IM final frame with 2 words -> DM writes at 0x3E8..0x434; in_ready held 1 throughout; cpu_rst drops only after the IM frame; words_loaded=22.
- Bound violation: IM header count 2, base 15 -> err=1 one cycle after the header; no wr_en; cpu_rst stays 1; in_ready=0 until rst.
- Early in_last on the 2nd of 3 expected words -> one write only (1st word), then ERR; header with in_last=1 -> ERR immediately.
- Bubbles: in_valid toggling 1,0,0,1 during DATA -> writes only one cycle after each transfer; addresses contiguous.
- rst asserted mid-DATA, then a new valid frame -> all outputs return to reset values; the new frame loads from offset 0.

Source files
------------

// File: rtl/mem_boot_pkg.sv
// Shared types and header field layout for the boot loader.
package mem_boot_pkg;

    typedef enum logic [1:0] {
        HDR  = 2'd0,
        DATA = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } bootState_t;

    localparam int TGT_BIT   = 31;
    localparam int FINAL_BIT = 30;
    localparam int CNT_LSB   = 16;

    localparam logic TGT_IM = 1'b0;
    localparam logic TGT_DM = 1'b1;

endpackage

// File: rtl/mem_boot_loader_if.sv
// Word-serial valid/ready stream feeding the boot loader.
interface mem_boot_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/mem_boot_hdr_check.sv
// Combinational header decode plus bound check against the target memory depth.
module mem_boot_hdr_check
    import mem_boot_pkg::*;
#(
    parameter int IM_WORDS = 16,
    parameter int DM_WORDS = 512,
    parameter int IDX_W    = 9
) (
    input  logic [31:0]    hdrWord,
    output logic           target,
    output logic           isFinal,
    output logic [IDX_W-1:0] base,
    output logic [IDX_W:0]   count,
    output logic           hdrBad
);

    localparam logic [IDX_W:0] IM_DEPTH = (IDX_W+1)'(IM_WORDS);
    localparam logic [IDX_W:0] DM_DEPTH = (IDX_W+1)'(DM_WORDS);

    logic [IDX_W:0] span;
    logic [IDX_W:0] depth;
    logic           unusedHdrBits;

    assign unusedHdrBits = ^{hdrWord[FINAL_BIT-1:CNT_LSB+IDX_W], hdrWord[CNT_LSB-1:IDX_W]};

    // Field extraction; base+count stays within IDX_W+1 bits so it cannot wrap.
    always_comb begin
        target  = hdrWord[TGT_BIT];
        isFinal = hdrWord[FINAL_BIT];
        base    = hdrWord[IDX_W-1:0];
        count   = {1'b0, hdrWord[CNT_LSB +: IDX_W]} + (IDX_W+1)'(1);
        span    = {1'b0, base} + count;
        depth   = (target == TGT_DM) ? DM_DEPTH : IM_DEPTH;
        hdrBad  = (span > depth);
    end

endmodule

// File: rtl/mem_boot_loader.sv
// Streams framed images into InstMem/DataMem and releases the core after the final frame.
//
// state | meaning
// HDR   | waiting for a frame header word
// DATA  | accepting payload words of the current frame
// DONE  | final frame loaded, core released
// ERR   | protocol error, core held in reset until rst
module mem_boot_loader
    import mem_boot_pkg::*;
#(
    parameter int IM_WORDS = 16,
    parameter int DM_WORDS = 512,
    parameter int IDX_W    = 9
) (
    input  logic               clk,
    input  logic               rst,
    mem_boot_loader_if.slave   inBus,
    output logic               wr_en,
    output logic               wr_sel,
    output logic [31:0]        wr_addr,
    output logic [31:0]        wr_data,
    output logic               cpu_rst,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [IDX_W:0]     words_loaded
);

    bootState_t state, nextState;

    logic             xfer;
    logic             latchHdr;
    logic             doWrite;

    logic             hdrTarget;
    logic             hdrFinal;
    logic [IDX_W-1:0] hdrBase;
    logic [IDX_W:0]   hdrCount;
    logic             hdrBad;

    logic             tgtReg;
    logic             finalReg;
    logic [IDX_W-1:0] baseReg;
    logic [IDX_W-1:0] offsetReg;
    logic [IDX_W:0]   remaining;
    logic [IDX_W:0]   wordIdx;

    mem_boot_hdr_check #(
        .IM_WORDS (IM_WORDS),
        .DM_WORDS (DM_WORDS),
        .IDX_W    (IDX_W)
    ) hdrCheck (
        .hdrWord (inBus.in_data),
        .target  (hdrTarget),
        .isFinal (hdrFinal),
        .base    (hdrBase),
        .count   (hdrCount),
        .hdrBad  (hdrBad)
    );

    assign inBus.in_ready = (state == HDR) || (state == DATA);
    assign xfer           = inBus.in_valid && inBus.in_ready;
    assign busy           = (state == DATA);
    assign done           = (state == DONE);
    assign err            = (state == ERR);
    assign cpu_rst        = (state != DONE);
    assign wordIdx        = {1'b0, baseReg} + {1'b0, offsetReg};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HDR;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode; a payload word that breaks framing is dropped, not written.
    always_comb begin
        nextState = state;
        latchHdr  = 1'b0;
        doWrite   = 1'b0;
        case (state)
            HDR: begin
                if (xfer) begin
                    if (hdrBad || inBus.in_last) begin
                        nextState = ERR;
                    end else begin
                        latchHdr  = 1'b1;
                        nextState = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    if ((remaining == '0) && inBus.in_last) begin
                        doWrite   = 1'b1;
                        nextState = finalReg ? DONE : HDR;
                    end else if ((remaining == '0) || inBus.in_last) begin
                        nextState = ERR;
                    end else begin
                        doWrite = 1'b1;
                    end
                end
            end
            DONE:    nextState = DONE;
            ERR:     nextState = ERR;
            default: nextState = ERR;
        endcase
    end

    // Frame context, offset/remaining counters and saturating word count.
    always_ff @(posedge clk) begin
        if (rst) begin
            tgtReg       <= TGT_IM;
            finalReg     <= 1'b0;
            baseReg      <= '0;
            offsetReg    <= '0;
            remaining    <= '0;
            words_loaded <= '0;
        end else begin
            if (latchHdr) begin
                tgtReg    <= hdrTarget;
                finalReg  <= hdrFinal;
                baseReg   <= hdrBase;
                offsetReg <= '0;
                remaining <= hdrCount - (IDX_W+1)'(1);
            end
            if (doWrite) begin
                offsetReg <= offsetReg + IDX_W'(1);
                if (remaining != '0) begin
                    remaining <= remaining - (IDX_W+1)'(1);
                end
                if (words_loaded != '1) begin
                    words_loaded <= words_loaded + (IDX_W+1)'(1);
                end
            end
        end
    end

    // Registered write port, one cycle behind the accepted payload word.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_sel  <= TGT_IM;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= doWrite;
            if (doWrite) begin
                wr_sel  <= tgtReg;
                wr_addr <= {{(32-IDX_W-3){1'b0}}, wordIdx, 2'b00};
                wr_data <= inBus.in_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_boot_loader.sv
// Directed bench for mem_boot_loader: load, multi-frame, error and reset scenarios.
module tb_mem_boot_loader;

    localparam int IDX_W = 9;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic             wr_sel;
    logic [31:0]      wr_addr;
    logic [31:0]      wr_data;
    logic             cpu_rst;
    logic             busy;
    logic             done;
    logic             err;
    logic [IDX_W:0]   words_loaded;

    mem_boot_loader_if bus();

    mem_boot_loader #(
        .IM_WORDS (16),
        .DM_WORDS (512),
        .IDX_W    (IDX_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inBus        (bus),
        .wr_en        (wr_en),
        .wr_sel       (wr_sel),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_rst      (cpu_rst),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    int nChecks = 0;
    int nFails  = 0;
    logic        capSel[$];
    logic [31:0] capAddr[$];
    logic [31:0] capData[$];
    logic        readyLow;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe seen just before each rising edge.
    always @(posedge clk) begin
        if (wr_en === 1'b1) begin
            capSel.push_back(wr_sel);
            capAddr.push_back(wr_addr);
            capData.push_back(wr_data);
        end
    end

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sendWord(input logic [31:0] d, input logic last);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        if (bus.in_ready !== 1'b1) readyLow = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_last  = 1'b0;
        end
    endtask

    task automatic clearCap();
        capSel.delete();
        capAddr.delete();
        capData.delete();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clearCap();
        readyLow = 1'b0;
    endtask

    initial begin
        logic vPat[6];
        logic lPat[6];
        logic prevValid;
        int   w;

        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
        readyLow     = 1'b0;

        // Reset values.
        repeat (2) @(negedge clk);
        checkVal("rst in_ready", bus.in_ready, 1);
        checkVal("rst wr_en", wr_en, 0);
        checkVal("rst wr_sel", wr_sel, 0);
        checkVal("rst wr_addr", wr_addr, 0);
        checkVal("rst wr_data", wr_data, 0);
        checkVal("rst cpu_rst", cpu_rst, 1);
        checkVal("rst busy", busy, 0);
        checkVal("rst done", done, 0);
        checkVal("rst err", err, 0);
        checkVal("rst words_loaded", words_loaded, 0);
        rst = 1'b0;
        clearCap();

        // Single final IM frame of 4 words at base 0.
        sendWord(32'h4003_0000, 1'b0);
        checkVal("t1 wr_en after reset", wr_en, 0);
        for (int i = 0; i < 4; i++) begin
            sendWord(32'hA000_0000 + 32'(i), (i == 3));
            if (i > 0) checkVal("t1 busy", busy, 1);
        end
        checkVal("t1 cpu_rst before done", cpu_rst, 1);
        idle(1);
        checkVal("t1 done", done, 1);
        checkVal("t1 cpu_rst released", cpu_rst, 0);
        checkVal("t1 in_ready in DONE", bus.in_ready, 0);
        checkVal("t1 last wr_en", wr_en, 1);
        idle(2);
        checkVal("t1 write count", capAddr.size(), 4);
        for (int i = 0; i < 4 && i < capAddr.size(); i++) begin
            checkVal($sformatf("t1 addr%0d", i), capAddr[i], 32'(i * 4));
            checkVal($sformatf("t1 sel%0d", i), capSel[i], 0);
            checkVal($sformatf("t1 data%0d", i), capData[i], 32'hA000_0000 + 32'(i));
        end
        checkVal("t1 words_loaded", words_loaded, 4);
        sendWord(32'hDEAD_BEEF, 1'b1);
        idle(2);
        checkVal("t1 ignored in DONE", capAddr.size(), 4);
        checkVal("t1 done sticky", done, 1);

        // DM frame of 20 words at base 250, then final IM frame of 2 words.
        doReset();
        sendWord(32'h8013_00FA, 1'b0);
        for (int i = 0; i < 20; i++) sendWord(32'hD000_0000 + 32'(i), (i == 19));
        sendWord(32'h4001_0000, 1'b0);
        checkVal("t2 cpu_rst between frames", cpu_rst, 1);
        checkVal("t2 busy between frames", busy, 0);
        for (int i = 0; i < 2; i++) sendWord(32'hC000_0000 + 32'(i), (i == 1));
        idle(3);
        checkVal("t2 in_ready held", readyLow, 0);
        checkVal("t2 write count", capAddr.size(), 22);
        if (capAddr.size() == 22) begin
            checkVal("t2 first DM addr", capAddr[0], 32'h0000_03E8);
            checkVal("t2 last DM addr", capAddr[19], 32'h0000_0434);
            for (int i = 0; i < 20; i++) begin
                checkVal($sformatf("t2 dm addr%0d", i), capAddr[i], 32'((250 + i) * 4));
                checkVal($sformatf("t2 dm sel%0d", i), capSel[i], 1);
                checkVal($sformatf("t2 dm data%0d", i), capData[i], 32'hD000_0000 + 32'(i));
            end
            for (int i = 0; i < 2; i++) begin
                checkVal($sformatf("t2 im addr%0d", i), capAddr[20 + i], 32'(i * 4));
                checkVal($sformatf("t2 im sel%0d", i), capSel[20 + i], 0);
                checkVal($sformatf("t2 im data%0d", i), capData[20 + i], 32'hC000_0000 + 32'(i));
            end
        end
        checkVal("t2 words_loaded", words_loaded, 22);
        checkVal("t2 done", done, 1);
        checkVal("t2 cpu_rst", cpu_rst, 0);

        // IM header count 2 at base 15 overruns 16-word memory.
        doReset();
        sendWord(32'h0001_000F, 1'b0);
        idle(1);
        checkVal("t3 err", err, 1);
        checkVal("t3 in_ready", bus.in_ready, 0);
        checkVal("t3 cpu_rst", cpu_rst, 1);
        sendWord(32'h1234_5678, 1'b0);
        sendWord(32'h1234_5679, 1'b1);
        idle(3);
        checkVal("t3 no writes", capAddr.size(), 0);
        checkVal("t3 err sticky", err, 1);
        checkVal("t3 in_ready sticky", bus.in_ready, 0);
        checkVal("t3 words_loaded", words_loaded, 0);

        // Early in_last on the 2nd of 3 words.
        doReset();
        sendWord(32'h0002_0000, 1'b0);
        sendWord(32'h1111_1111, 1'b0);
        sendWord(32'h2222_2222, 1'b1);
        idle(1);
        checkVal("t4 err", err, 1);
        checkVal("t4 wr_en dropped", wr_en, 0);
        idle(2);
        checkVal("t4 write count", capAddr.size(), 1);
        if (capAddr.size() >= 1) begin
            checkVal("t4 addr", capAddr[0], 0);
            checkVal("t4 data", capData[0], 32'h1111_1111);
        end
        checkVal("t4 words_loaded", words_loaded, 1);
        checkVal("t4 cpu_rst", cpu_rst, 1);

        // Header carrying in_last.
        doReset();
        sendWord(32'h4000_0000, 1'b1);
        idle(1);
        checkVal("t4b err", err, 1);
        checkVal("t4b in_ready", bus.in_ready, 0);
        idle(2);
        checkVal("t4b no writes", capAddr.size(), 0);

        // Bubbles inside a 3-word final frame.
        doReset();
        vPat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        lPat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        sendWord(32'h4002_0000, 1'b0);
        prevValid = 1'b0;
        w = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkVal($sformatf("t5 wr_en cyc%0d", i), wr_en, prevValid);
            bus.in_valid = vPat[i];
            bus.in_last  = lPat[i];
            bus.in_data  = 32'h5000_0000 + 32'(w);
            if (vPat[i]) w++;
            prevValid = vPat[i];
        end
        idle(1);
        checkVal("t5 wr_en final", wr_en, 1);
        idle(2);
        checkVal("t5 write count", capAddr.size(), 3);
        for (int i = 0; i < 3 && i < capAddr.size(); i++) begin
            checkVal($sformatf("t5 addr%0d", i), capAddr[i], 32'(i * 4));
            checkVal($sformatf("t5 data%0d", i), capData[i], 32'h5000_0000 + 32'(i));
        end
        checkVal("t5 done", done, 1);

        // Reset mid-frame, then a fresh frame at base 8.
        doReset();
        sendWord(32'h0004_0000, 1'b0);
        sendWord(32'h6000_0000, 1'b0);
        sendWord(32'h6000_0001, 1'b0);
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h6000_0002;
        bus.in_last  = 1'b0;
        @(negedge clk);
        checkVal("t6 wr_en", wr_en, 0);
        checkVal("t6 wr_addr", wr_addr, 0);
        checkVal("t6 wr_data", wr_data, 0);
        checkVal("t6 busy", busy, 0);
        checkVal("t6 cpu_rst", cpu_rst, 1);
        checkVal("t6 in_ready", bus.in_ready, 1);
        checkVal("t6 words_loaded", words_loaded, 0);
        checkVal("t6 pre-reset writes", capAddr.size(), 2);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        clearCap();
        sendWord(32'h4001_0008, 1'b0);
        sendWord(32'h7000_0000, 1'b0);
        sendWord(32'h7000_0001, 1'b1);
        idle(3);
        checkVal("t6 write count", capAddr.size(), 2);
        if (capAddr.size() == 2) begin
            checkVal("t6 addr0", capAddr[0], 32'h20);
            checkVal("t6 addr1", capAddr[1], 32'h24);
            checkVal("t6 data1", capData[1], 32'h7000_0001);
        end
        checkVal("t6 new words_loaded", words_loaded, 2);
        checkVal("t6 done", done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
